// File: rtl/ks_frame_loader.sv
// ---------------------------------------------------------------------------
// ks_frame_loader
//
// Input stage for the "101" sequence-detector experiment. An 8-bit frame Ks
// is assembled one bit per accepted button press. Bit 0 is captured first.
// Each press samples the data switch DIN. After the eighth capture the frame
// is held stable, VALID goes high and DONE pulses for one cycle. The next
// press starts a fresh frame.
//
// Parameters
//   DEB_CYCLES : consecutive differing samples needed to accept a STEP change
//                (>= 2; 1_000_000 is 20 ms at 50 MHz)
//   DEB_W      : debounce counter width, 2**DEB_W > DEB_CYCLES
//
// Ports
//   CLK   in   rising-edge clock
//   RST   in   asynchronous active-low reset
//   DIN   in   raw data switch (asynchronous)
//   STEP  in   raw push button, active-high, bouncing (asynchronous)
//   CLR   in   raw clear switch, active-high (asynchronous, not debounced)
//   Ks    out  assembled frame; bit i comes from press i+1
//   VALID out  high while Ks holds a complete 8-bit frame
//   DONE  out  one-cycle pulse on the cycle VALID rises
//   CNT   out  bits captured in the current frame, 0..8
//   LED   out  position indicator, LED[i] = (i < CNT)
//
// Every output is a flop. No combinational path runs from an input to an
// output.
// ---------------------------------------------------------------------------
module ks_frame_loader #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DIN,
  input  logic       STEP,
  input  logic       CLR,
  output logic [7:0] Ks,
  output logic       VALID,
  output logic       DONE,
  output logic [3:0] CNT,
  output logic [7:0] LED
);

  // The counter value at which the current differing sample is the
  // DEB_CYCLES-th consecutive one.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // One-hot frame state.
  typedef enum logic [2:0] {
    S_EMPTY = 3'b001,
    S_LOAD  = 3'b010,
    S_FULL  = 3'b100
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronisers. Index 1 is the synchronised output.
  // -------------------------------------------------------------------------
  logic [1:0] din_sync_q,  din_sync_d;
  logic [1:0] step_sync_q, step_sync_d;
  logic [1:0] clr_sync_q,  clr_sync_d;
  logic       din_s, step_s, clr_s;

  always_comb begin
    din_sync_d  = {din_sync_q[0],  DIN};
    step_sync_d = {step_sync_q[0], STEP};
    clr_sync_d  = {clr_sync_q[0],  CLR};
  end

  assign din_s  = din_sync_q[1];
  assign step_s = step_sync_q[1];
  assign clr_s  = clr_sync_q[1];

  // -------------------------------------------------------------------------
  // Debouncer. step_db_q is the accepted level. step_db_dly_q is that level
  // one cycle later and is used for rising-edge detection.
  // -------------------------------------------------------------------------
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             step_db_q, step_db_d;
  logic             step_db_dly_q, step_db_dly_d;
  logic             evt;

  // NOTE: every combinational output gets a default value before any branch.
  // Without that, a path that leaves a signal unassigned infers a latch.
  always_comb begin
    deb_cnt_d     = '0;
    step_db_d     = step_db_q;
    step_db_dly_d = step_db_q;
    if (step_s != step_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        // This sample is the DEB_CYCLES-th consecutive differing one.
        step_db_d = ~step_db_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Fires only on a debounced press. A release never creates an event.
  assign evt = step_db_q & ~step_db_dly_q;

  // -------------------------------------------------------------------------
  // Frame state machine
  // -------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [7:0] ks_q, ks_d;
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic [7:0] led_q, led_d;

  always_comb begin
    state_d = state_q;
    ks_d    = ks_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if (clr_s) begin
      // Clear wins over a simultaneous event, and that press is dropped.
      state_d = S_EMPTY;
      ks_d    = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (evt) begin
            ks_d    = {7'b0, din_s};
            cnt_d   = 4'd1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (evt) begin
            // Positions above cnt_q are still 0, so only one bit is written.
            ks_d[cnt_q[2:0]] = din_s;
            cnt_d            = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              state_d = S_FULL;
              valid_d = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
        S_FULL: begin
          if (evt) begin
            // A new frame starts with no leftover bits from the previous one.
            ks_d    = {7'b0, din_s};
            cnt_d   = 4'd1;
            valid_d = 1'b0;
            state_d = S_LOAD;
          end
        end
        default: begin
          // An illegal one-hot code goes back to a clean empty frame.
          state_d = S_EMPTY;
          ks_d    = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end

    // The LED bar follows the next count so that it updates on the same edge
    // as CNT.
    for (int i = 0; i < 8; i++) begin
      led_d[i] = (4'(i) < cnt_d);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together, and the order of the statements does not matter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      din_sync_q    <= '0;
      step_sync_q   <= '0;
      clr_sync_q    <= '0;
      deb_cnt_q     <= '0;
      step_db_q     <= 1'b0;
      step_db_dly_q <= 1'b0;
      state_q       <= S_EMPTY;
      ks_q          <= '0;
      cnt_q         <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      led_q         <= '0;
    end else begin
      din_sync_q    <= din_sync_d;
      step_sync_q   <= step_sync_d;
      clr_sync_q    <= clr_sync_d;
      deb_cnt_q     <= deb_cnt_d;
      step_db_q     <= step_db_d;
      step_db_dly_q <= step_db_dly_d;
      state_q       <= state_d;
      ks_q          <= ks_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      led_q         <= led_d;
    end
  end

  assign Ks    = ks_q;
  assign VALID = valid_q;
  assign DONE  = done_q;
  assign CNT   = cnt_q;
  assign LED   = led_q;

endmodule

// File: tb/tb_ks_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_ks_frame_loader
//
// Directed bench for ks_frame_loader with DEB_CYCLES=4 and DEB_W=3. Inputs
// change on the falling clock edge and outputs are sampled on the falling
// edge. So "after edge n" means the falling edge that follows the n-th rising
// edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ks_frame_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din, step, clr;
  logic [7:0] ks;
  logic       valid, done;
  logic [3:0] cnt;
  logic [7:0] led;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // Expected frame, tracked by the bench.
  logic [7:0] exp_ks;
  logic [3:0] exp_cnt;
  logic       exp_valid;

  ks_frame_loader #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .DIN  (din),
    .STEP (step),
    .CLR  (clr),
    .Ks   (ks),
    .VALID(valid),
    .DONE (done),
    .CNT  (cnt),
    .LED  (led)
  );

  always #5 clk = ~clk;

  // Counts every cycle in which DONE was high.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] led_of(input logic [3:0] c);
    logic [7:0] l;
    for (int i = 0; i < 8; i++) l[i] = (i < int'(c));
    return l;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clean press. Press and hold for 10 cycles, then release for 10.
  // The capture must appear after edge 7 and not after edge 6.
  task automatic press(input logic d);
    logic exp_done;
    @(negedge clk);
    din  = d;
    step = 1'b1;
    tick(6);
    check("pre_capture_cnt", cnt, exp_cnt);
    check("pre_capture_ks", ks, exp_ks);
    tick(1);
    exp_done = 1'b0;
    if (exp_cnt == 4'd8) begin
      exp_ks    = {7'b0, d};
      exp_cnt   = 4'd1;
      exp_valid = 1'b0;
    end else begin
      exp_ks[exp_cnt[2:0]] = d;
      exp_cnt = exp_cnt + 4'd1;
      if (exp_cnt == 4'd8) begin
        exp_valid = 1'b1;
        exp_done  = 1'b1;
      end
    end
    check("capture_cnt", cnt, exp_cnt);
    check("capture_ks", ks, exp_ks);
    check("capture_led", led, led_of(exp_cnt));
    check("capture_valid", valid, exp_valid);
    check("capture_done", done, exp_done);
    tick(1);
    check("done_falls", done, 0);
    tick(2);
    step = 1'b0;
    tick(10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ks"}, ks, 0);
    check({tag, "_cnt"}, cnt, 0);
    check({tag, "_led"}, led, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int done_base;
    logic [7:0] frame_bits;

    // ---------------- Reset values ----------------
    rst_n = 1'b0;
    din   = 1'b0;
    step  = 1'b0;
    clr   = 1'b0;
    exp_ks = '0; exp_cnt = '0; exp_valid = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check_all_zero("reset");

    // ---------------- Full frame 1,0,1,1,0,1,0,1 ----------------
    frame_bits = 8'b10101101;
    done_base = done_cnt;
    for (int i = 0; i < 8; i++) press(frame_bits[i]);
    check("frame_ks", ks, 8'b10101101);
    check("frame_cnt", cnt, 8);
    check("frame_led", led, 8'hFF);
    check("frame_valid", valid, 1);
    check("frame_done_pulses", done_cnt - done_base, 1);

    // ---------------- Clear from FULL: VALID falls 3 edges after CLR ----------------
    @(negedge clk);
    clr = 1'b1;
    tick(2);
    check("clr_valid_edge2", valid, 1);
    tick(1);
    check("clr_valid_edge3", valid, 0);
    check("clr_ks", ks, 0);
    check("clr_cnt", cnt, 0);
    clr = 1'b0;
    tick(4);
    exp_ks = '0; exp_cnt = '0; exp_valid = 1'b0;

    // ---------------- Bounce rejection ----------------
    @(negedge clk);
    din = 1'b1;
    step = 1'b1; tick(1); step = 1'b0; tick(1);
    step = 1'b1; tick(2); step = 1'b0; tick(1);
    step = 1'b1; tick(3); step = 1'b0; tick(1);
    check("bounce_no_early_capture", cnt, 0);
    step = 1'b1; tick(10);
    step = 1'b0; tick(10);
    check("bounce_cnt", cnt, 1);
    check("bounce_ks", ks, 8'h01);
    exp_ks = 8'h01; exp_cnt = 4'd1;

    step = 1'b1; tick(3);
    step = 1'b0; tick(10);
    check("lone_pulse_cnt", cnt, 1);
    check("lone_pulse_ks", ks, 8'h01);

    // ---------------- Fill to 8'hFF, then wrap ----------------
    done_base = done_cnt;
    for (int i = 0; i < 7; i++) press(1'b1);
    check("ff_ks", ks, 8'hFF);
    check("ff_done_pulses", done_cnt - done_base, 1);

    done_base = done_cnt;
    press(1'b0);
    check("wrap_ks", ks, 8'h00);
    check("wrap_cnt", cnt, 1);
    check("wrap_valid", valid, 0);
    check("wrap_no_done", done_cnt - done_base, 0);
    for (int i = 0; i < 7; i++) press(1'b1);
    check("wrap_fe_ks", ks, 8'hFE);
    check("wrap_fe_done_pulses", done_cnt - done_base, 1);

    // ---------------- Clear priority ----------------
    @(negedge clk);
    clr = 1'b1;
    tick(4);
    clr = 1'b0;
    tick(4);
    exp_ks = '0; exp_cnt = '0; exp_valid = 1'b0;
    press(1'b1); press(1'b1); press(1'b0);
    @(negedge clk);
    din  = 1'b1;
    step = 1'b1;
    tick(4);
    clr = 1'b1;      // sampled by edge 5, so clr_s rises with evt after edge 6
    tick(2);
    check("clrpri_before_cnt", cnt, 3);
    tick(1);
    check("clrpri_cnt", cnt, 0);
    check("clrpri_ks", ks, 0);
    check("clrpri_led", led, 0);
    clr = 1'b0;
    tick(3);
    step = 1'b0;
    tick(10);
    check("clrpri_press_lost", cnt, 0);

    // ---------------- Reset mid-operation ----------------
    exp_ks = '0; exp_cnt = '0; exp_valid = 1'b0;
    press(1'b1); press(1'b0); press(1'b1); press(1'b0); press(1'b1);
    check("pre_reset_cnt", cnt, 5);
    @(negedge clk);
    step = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_all_zero("post_reset");
    exp_ks = '0; exp_cnt = '0; exp_valid = 1'b0;
    press(1'b1);
    check("post_reset_ks", ks, 8'h01);
    check("post_reset_cnt", cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ks_frame_loader.md
# ks_frame_loader

Upstream input stage for the "101" sequence-detector experiment. It builds the 8-bit pattern `Ks` one bit at a time from a single data switch, `DIN`, and a bouncing push button, `STEP`. Each accepted press captures `DIN` into the next bit position, starting with bit 0. After 8 presses it presents a complete, stable frame and strobes `DONE`. The detector then evaluates `Ks`.

## Interface
- `DEB_CYCLES`, default 1000000: consecutive stable samples required to accept a `STEP` level change. Minimum 2. The default gives 20 ms at 50 MHz.
- `DEB_W`, default 20: width of the debounce counter. Must satisfy 2^`DEB_W` > `DEB_CYCLES`.
- `CLK`, input, 1: the only clock. All flops are rising-edge.
- `RST`, input, 1: asynchronous, active-low reset.
- `DIN`, input, 1: raw data switch. Asynchronous to `CLK`.
- `STEP`, input, 1: raw push button, active-high. Asynchronous and bouncing.
- `CLR`, input, 1: raw clear switch, active-high. Asynchronous and not debounced.
- `Ks`, output, 8: assembled frame. Bit i is the value captured on press i+1.
- `VALID`, output, 1: high while `Ks` holds a complete 8-bit frame.
- `DONE`, output, 1: one-cycle pulse on the cycle `VALID` rises.
- `CNT`, output, 4: number of bits captured in the current frame, 0..8.
- `LED`, output, 8: bit-position indicator. `LED[i]` is 1 for every captured position i < `CNT`.

## Operation
- **Synchronisers:** `DIN`, `STEP` and `CLR` each pass through a 2-flop synchroniser. The outputs are `din_s`, `step_s` and `clr_s`.
- **Debouncer:**
  - The register `step_db` holds the debounced level. It resets to 0.
  - The counter increments on each cycle where `step_s` != `step_db`, and clears on any cycle where they match.
  - When the counter has seen `DEB_CYCLES` consecutive differing samples, `step_db` toggles and the counter clears.
- **Step event:** `evt` = `step_db` & ~`step_db_d`, where `step_db_d` is `step_db` delayed by one flop. `evt` is one cycle wide per accepted press. Release never produces an event.
- **State machine:** one-hot, with states EMPTY, LOAD and FULL.
  - **EMPTY** (`CNT`=0, `Ks`=0). On `evt`:
    - `Ks[0]` <= `din_s`, `CNT` <= 1, go to LOAD.
  - **LOAD** (`CNT` 1..7). On `evt`:
    - `Ks[CNT]` <= `din_s`, `CNT` <= `CNT`+1.
    - If the new `CNT` is 8: go to FULL, `VALID` <= 1, and `DONE` is high for that one cycle.
  - **FULL** (`CNT`=8). `Ks` is held unchanged. On `evt`, a new frame starts:
    - `Ks` <= {7'b0, `din_s`}, `CNT` <= 1, `VALID` <= 0, go to LOAD.
- **Clear:** while `clr_s`=1, go to EMPTY, with `Ks`, `CNT`, `VALID` and `DONE` all 0. `CLR` takes priority over a simultaneous `evt`, and that press is lost.
- **Positions not yet captured:** these stay 0. `Ks` never contains bits left over from a previous frame.
- **Reset:** asserting `RST` at any time, including mid-frame or mid-debounce, immediately forces:
  - State EMPTY.
  - `Ks`, `CNT`, `LED`, `VALID` and `DONE` to 0.
  - The debounce counter, `step_db`, `step_db_d` and all synchroniser flops to 0.
- **Held button:** holding `STEP` produces exactly one event. A further event needs a debounced release followed by a debounced press.

## Timing
- Let edge 1 be the first `CLK` edge that samples `STEP`=1, with `STEP` held stable after that.
  - `step_s`=1 after edge 2.
  - `step_db` rises after edge `DEB_CYCLES`+2.
  - The capture into `Ks` and `CNT` is visible after edge `DEB_CYCLES`+3.
- The captured `DIN` value is `din_s` at the capture edge, i.e. raw `DIN` as sampled 2 edges earlier.
- `DONE` and `VALID` rise after the same edge as the 8th capture.
  - `DONE` falls after the following edge.
  - `VALID` falls after the capture edge of the next frame's first bit, or 3 edges after `CLR` rises.
- Bounce rejection:
  - Any `STEP` pulse or bounce train that keeps `step_s` differing from `step_db` for fewer than `DEB_CYCLES` consecutive cycles produces no event.
  - Bounces during a held press do not retrigger.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Use `DEB_CYCLES`=4 and `DEB_W`=3 throughout.
- **Reset values:** `RST`=0 at time 0, then 1 → `Ks`=0, `CNT`=0, `LED`=0, `VALID`=0, `DONE`=0.
- **Full frame:** 8 clean presses, each held 10 cycles with 10 released, with `DIN` = 1,0,1,1,0,1,0,1 (bit 0 first) → `Ks`=8'b10101101, `CNT`=8, `LED`=8'hFF, `VALID`=1, and exactly one `DONE` pulse. Check that each capture occurs exactly 7 edges after `STEP` is first sampled high.
- **Bounce rejection:** a press preceded by 1-, 2- and 3-cycle glitches, with 1-cycle low gaps between them, then a stable hold of 10 cycles → `CNT` increments by exactly 1. A lone 3-cycle pulse → `CNT` unchanged.
- **Wrap-around:** from FULL with `Ks`=8'hFF, press once with `DIN`=0 → `Ks`=8'h00, `CNT`=1, `VALID`=0, no `DONE`. Seven further presses with `DIN`=1 → `Ks`=8'hFE, one `DONE`.
- **Clear priority:** after 3 captures, raise `CLR` on the same cycle a press completes debounce → `CNT`=0, `Ks`=0, state EMPTY, and that press is not captured.
- **Reset mid-operation:** assert `RST` after 5 captures and mid-debounce of the 6th press, then release → all outputs 0. A new clean press with `DIN`=1 → `Ks`=8'h01, `CNT`=1.
